// File: rtl/elevator_pkg.sv
// Shared types and constants for the hall-call front end.
// Floor vectors are indexed by landing number (bit f = floor f).
package elevator_pkg;

    localparam int N_FLOORS = 4;
    localparam int FLOOR_W  = $clog2(N_FLOORS);

    typedef logic [FLOOR_W-1:0]  floor_t;
    typedef logic [N_FLOORS-1:0] floor_vec_t;

    // The top landing has no up button and the bottom landing has no down button.
    localparam floor_vec_t UP_MASK   = ~(floor_vec_t'(1) << (N_FLOORS - 1));
    localparam floor_vec_t DOWN_MASK = ~floor_vec_t'(1);

    // One-hot vector of the floor whose calls are being served right now.
    function automatic floor_vec_t service_vec(input floor_t cur, input logic door);
        floor_vec_t result;
        result = '0;
        if (door) begin
            result = floor_vec_t'(1) << cur;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single hall button: two-flop synchroniser followed by a counting debouncer.
// The debounced level changes only after DB_CYCLES consecutive synchronised
// samples that disagree with it; 'rise' marks the edge on which it goes 0->1.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             deb;
    logic [CNT_W-1:0] cnt;
    logic             toggle;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // The level flips on the sample that would take the count past its last value.
    assign toggle = (sync_out != deb) && (cnt == CNT_LAST);

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync_out == deb) begin
            cnt <= '0;
        end else if (toggle) begin
            deb <= ~deb;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = deb;
    assign rise  = toggle && !deb;

endmodule

// File: rtl/hall_call_panel.sv
// Hall-call front end: debounces landing buttons, latches accepted calls into
// lamps, pulses up_req/down_req once per new call, and clears a floor's lamps
// while the car stands there with the door open.
module hall_call_panel
    import elevator_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] btn_up,
    input  logic [N_FLOORS-1:0] btn_down,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                door_open,
    output logic [N_FLOORS-1:0] up_req,
    output logic [N_FLOORS-1:0] down_req,
    output logic [N_FLOORS-1:0] up_lamp,
    output logic [N_FLOORS-1:0] down_lamp
);

    floor_vec_t up_rise;
    floor_vec_t down_rise;
    floor_vec_t up_level_unused;
    floor_vec_t down_level_unused;
    floor_vec_t service;
    floor_vec_t up_accept;
    floor_vec_t down_accept;
    logic       masked_buttons_unused;

    // The non-existent buttons are wired to the pins but deliberately ignored.
    assign masked_buttons_unused = btn_up[N_FLOORS-1] ^ btn_down[0];

    for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
        if (UP_MASK[f]) begin : g_up
            btn_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_up (
                .clk   (clk),
                .reset (reset),
                .raw   (btn_up[f]),
                .level (up_level_unused[f]),
                .rise  (up_rise[f])
            );
        end else begin : g_up_masked
            assign up_rise[f]         = 1'b0;
            assign up_level_unused[f] = 1'b0;
        end

        if (DOWN_MASK[f]) begin : g_down
            btn_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_down (
                .clk   (clk),
                .reset (reset),
                .raw   (btn_down[f]),
                .level (down_level_unused[f]),
                .rise  (down_rise[f])
            );
        end else begin : g_down_masked
            assign down_rise[f]         = 1'b0;
            assign down_level_unused[f] = 1'b0;
        end
    end

    assign service = service_vec(floor_t'(current_floor), door_open);

    // A press is new only if its lamp is dark and the car is not already serving that floor.
    assign up_accept   = up_rise   & ~up_lamp   & ~service & UP_MASK;
    assign down_accept = down_rise & ~down_lamp & ~service & DOWN_MASK;

    // Latch accepted calls and emit their one-cycle request; serving a floor clears both lamps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_lamp   <= '0;
            down_lamp <= '0;
            up_req    <= '0;
            down_req  <= '0;
        end else begin
            up_lamp   <= (up_lamp   | up_accept)   & ~service;
            down_lamp <= (down_lamp | down_accept) & ~service;
            up_req    <= up_accept;
            down_req  <= down_accept;
        end
    end

endmodule

// File: tb/tb_hall_call_panel.sv
// Scoreboard bench for hall_call_panel: stimulus pushes the expected request
// pulse (with the edge it must appear after); a monitor pops on every pulse.
module tb_hall_call_panel;

    // Inputs driven at a falling edge are first sampled on the next rising edge
    // k, and the request appears after edge k+1+DB_CYCLES: six edges later.
    localparam int LAT = 6;

    typedef struct {
        int         cyc;
        logic [3:0] up;
        logic [3:0] dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_up = 4'b0000;
    logic [3:0] btn_down = 4'b0000;
    logic [1:0] current_floor = 2'd0;
    logic       door_open = 1'b0;
    logic [3:0] up_req;
    logic [3:0] down_req;
    logic [3:0] up_lamp;
    logic [3:0] down_lamp;

    exp_t exp_q[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    hall_call_panel #(
        .DB_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .current_floor (current_floor),
        .door_open     (door_open),
        .up_req        (up_req),
        .down_req      (down_req),
        .up_lamp       (up_lamp),
        .down_lamp     (down_lamp)
    );

    always #5 clk = ~clk;

    // Monitor: count edges and match every presented request pulse against the queue.
    always @(posedge clk) begin
        edge_cnt++;
        #1;
        if ((up_req | down_req) != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_req edge %0d: up_req=%b down_req=%b, required no pulse",
                         edge_cnt, up_req, down_req);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != edge_cnt || mon_e.up !== up_req || mon_e.dn !== down_req) begin
                    errors++;
                    $display("[TB] FAIL req_pulse: edge %0d up_req=%b down_req=%b, required edge %0d up_req=%b down_req=%b",
                             edge_cnt, up_req, down_req, mon_e.cyc, mon_e.up, mon_e.dn);
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] up, input logic [3:0] dn,
                                 input logic [1:0] flr, input logic door);
        btn_up        = up;
        btn_down      = dn;
        current_floor = flr;
        door_open     = door;
    endtask

    task automatic expectReq(input logic [3:0] up, input logic [3:0] dn);
        exp_t e;
        e.cyc = edge_cnt + LAT;
        e.up  = up;
        e.dn  = dn;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_up_lamp,
                               input logic [3:0] exp_down_lamp);
        checks++;
        if (up_lamp !== exp_up_lamp || down_lamp !== exp_down_lamp ||
            up_req !== 4'b0000 || down_req !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL %s: up_lamp=%b down_lamp=%b up_req=%b down_req=%b, required up_lamp=%b down_lamp=%b reqs=0000",
                     name, up_lamp, down_lamp, up_req, down_req, exp_up_lamp, exp_down_lamp);
        end
    endtask

    initial begin
        $display("[TB] hall_call_panel bench start");
        waitCycles(3);
        checkOutput("reset_hold", 4'b0000, 4'b0000);
        reset = 1'b0;
        waitCycles(2);

        // Up call at floor 2, car at floor 0 with door closed.
        applyStimulus(4'b0100, 4'b0000, 2'd0, 1'b0);
        expectReq(4'b0100, 4'b0000);
        waitCycles(8);
        checkOutput("up2_lamp", 4'b0100, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0);
        waitCycles(8);
        checkOutput("up2_release", 4'b0100, 4'b0000);

        // Three-cycle glitch is rejected, four-cycle press is accepted.
        applyStimulus(4'b0000, 4'b1000, 2'd0, 1'b0);
        waitCycles(3);
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0);
        waitCycles(10);
        checkOutput("down3_glitch", 4'b0100, 4'b0000);
        applyStimulus(4'b0000, 4'b1000, 2'd0, 1'b0);
        expectReq(4'b0000, 4'b1000);
        waitCycles(4);
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0);
        waitCycles(10);
        checkOutput("down3_pulse", 4'b0100, 4'b1000);

        // Up call at floor 1, then a re-press while lit gives no second pulse.
        applyStimulus(4'b0010, 4'b0000, 2'd0, 1'b0);
        expectReq(4'b0010, 4'b0000);
        waitCycles(8);
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0);
        waitCycles(8);
        checkOutput("up1_lamp", 4'b0110, 4'b1000);
        applyStimulus(4'b0010, 4'b0000, 2'd0, 1'b0);
        waitCycles(8);
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0);
        waitCycles(8);
        checkOutput("up1_repress", 4'b0110, 4'b1000);

        // Serving floors 1 and 2 clears their lamps on the next edge.
        applyStimulus(4'b0000, 4'b0000, 2'd1, 1'b1);
        waitCycles(1);
        checkOutput("service_f1", 4'b0100, 4'b1000);
        applyStimulus(4'b0000, 4'b0000, 2'd2, 1'b1);
        waitCycles(1);
        checkOutput("service_f2", 4'b0000, 4'b1000);

        // Door open at floor 2: its down press is dropped, floor 0 up is accepted.
        applyStimulus(4'b0001, 4'b0100, 2'd2, 1'b1);
        expectReq(4'b0001, 4'b0000);
        waitCycles(8);
        checkOutput("open_floor_drop", 4'b0001, 4'b1000);
        applyStimulus(4'b0000, 4'b0100, 2'd2, 1'b0);
        waitCycles(10);
        checkOutput("held_through_service", 4'b0001, 4'b1000);
        applyStimulus(4'b0000, 4'b0000, 2'd2, 1'b0);
        waitCycles(8);
        applyStimulus(4'b0000, 4'b0100, 2'd2, 1'b0);
        expectReq(4'b0000, 4'b0100);
        waitCycles(8);
        applyStimulus(4'b0000, 4'b0000, 2'd2, 1'b0);
        waitCycles(8);
        checkOutput("down2_repress", 4'b0001, 4'b1100);

        // Door opens at floor 0 on the very edge its up press would be accepted.
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b1);
        waitCycles(1);
        checkOutput("service_f0", 4'b0000, 4'b1100);
        applyStimulus(4'b0001, 4'b0000, 2'd0, 1'b0);
        waitCycles(5);
        applyStimulus(4'b0001, 4'b0000, 2'd0, 1'b1);
        waitCycles(2);
        checkOutput("clear_beats_accept", 4'b0000, 4'b1100);
        applyStimulus(4'b0001, 4'b0000, 2'd0, 1'b0);
        waitCycles(8);
        checkOutput("no_rereq_after_close", 4'b0000, 4'b1100);
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0);
        waitCycles(8);

        // Masked buttons held long are ignored; two floors pulse together.
        applyStimulus(4'b1000, 4'b0001, 2'd1, 1'b0);
        waitCycles(20);
        checkOutput("masked_held", 4'b0000, 4'b1100);
        applyStimulus(4'b0101, 4'b0000, 2'd1, 1'b0);
        expectReq(4'b0101, 4'b0000);
        waitCycles(8);
        checkOutput("multi_floor", 4'b0101, 4'b1100);

        // Reset with lamps lit while floor 1 up is held through release.
        applyStimulus(4'b0010, 4'b0000, 2'd1, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_run", 4'b0000, 4'b0000);
        waitCycles(3);
        reset = 1'b0;
        expectReq(4'b0010, 4'b0000);
        waitCycles(8);
        checkOutput("held_through_reset", 4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 2'd1, 1'b0);
        waitCycles(10);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_req: %0d pulses outstanding, required 0 (next due edge %0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
